history_reader: RTL and testbench
=================================

Name: history_reader

Overview:
- Read-side companion to the memory-based delay chain.
- A free-running writer stores the input stream into a circular RAM on every `en`.
- On request, the block streams out a window of past samples: `len` samples starting `lag` samples back from the newest sample.
- The window is delivered over a valid/ready output. Used for trigger-capture readout and look-back analysis next to DSP delay lines.

Parameters:
- DW, 8, sample data width.
- DEPTH, 32, history length in samples; any value >= 2, not required to be a power of two.
- LW, $clog2(DEPTH+1), derived width of `req_lag` and `req_len`; not user-set.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  write strobe; `din` is stored when high.
- din  in  DW  input sample.
- req  in  1  read request; accepted only when `req_ready` is high.
- req_lag  in  LW  distance from the newest sample to the first sample read. 1 = newest sample.
- req_len  in  LW  number of samples to emit.
- req_ready  out  1  high in IDLE.
- req_err  out  1  one-cycle pulse when a request is rejected.
- dout  out  DW  output sample.
- dout_valid  out  1  `dout` is valid.
- dout_ready  in  1  downstream accepts `dout`.
- dout_last  out  1  marks the final sample of the window; qualified by `dout_valid`.
- fill  out  LW  number of valid history samples, saturating at DEPTH.

Behaviour:
- Reset (async assert, release on the clk edge): wptr=0, fill=0, state=IDLE, req_ready=1, req_err=0, dout_valid=0, dout_last=0, dout=0. Reset mid-readout aborts the window; no partial data appears afterwards.
- Writer:
  - On an `en` edge, RAM[wptr] <= din.
  - wptr increments and wraps DEPTH-1 -> 0.
  - fill increments and saturates at DEPTH.
  - Writes are frozen (en ignored) while state != IDLE. Exception: see the optional feature.
- Request: evaluated on a clk edge with req && req_ready.
  - Valid iff 1 <= req_lag <= fill and 1 <= req_len <= req_lag.
  - Invalid: req_err pulses for exactly one cycle, state stays IDLE, nothing is emitted.
  - Valid: raddr = (wptr - req_lag) mod DEPTH, computed with LW+1-bit arithmetic and a conditional +DEPTH. The remaining count is loaded with req_len. State -> READ.
  - `en` in the same cycle as an accepted `req`: the write happens, and lag is computed against the pre-write wptr.
- States:
  - IDLE: accepts requests as above.
  - READ: issues one synchronous RAM read per cycle while output buffer space exists. raddr wraps DEPTH-1 -> 0. The count decrements per issued read. Count reaching 0 -> DRAIN.
  - DRAIN: waits until the last sample is handshaken (dout_valid && dout_ready && dout_last), then -> IDLE.
- Output buffer:
  - RAM read latency is 1 cycle.
  - A 2-entry skid buffer guarantees no sample loss when dout_ready drops.
  - dout, dout_valid and dout_last are registered outputs.
  - dout and dout_last are held stable while dout_valid && !dout_ready.
- Latency: the first dout_valid rises 2 cycles after the accepting edge.
- Throughput: 1 sample/cycle while dout_ready=1.
- dout_last is asserted with sample number req_len.
- req_ready returns high in the cycle after the last handshake.

Optional Feature:
- Macro: HISTORY_READER_LIVE_EN.
- Defined:
  - `en` writes continue during READ/DRAIN.
  - Adds an output port `overrun`, a sticky flag cleared on request accept.
  - `overrun` sets if a write hits an address still pending read, i.e. the write pointer catches raddr while the remaining count > 0.
  - Data after an overrun is undefined, but the window length and the dout_last position are unchanged.
- Undefined: writes are frozen as described in Behaviour; no `overrun` port exists.

Decomposition:
- Package history_reader_pkg holds:
  - the state enum: IDLE, READ, DRAIN;
  - the function computing LW from DEPTH;
  - the wrap-add helper for (a - b) mod DEPTH.
- Sub-module sdp_ram_rf: simple dual-port RAM, one write port and one synchronous read port, read-first.
- The skid buffer stays inline.

Test Plan (DW=8, DEPTH=8 unless noted):
- Write 1..10 with en=1, then req lag=3 len=3, dout_ready=1 -> dout 8,9,10; last on 10; first valid 2 cycles after accept; fill=8.
- After reset, write 5 samples (0x11..0x15), then req lag=6 -> req_err 1-cycle pulse, req_ready stays 1, no dout_valid. Also check lag=0, len=0, and len=4 with lag=3: each -> req_err.
- Wrap case: write 1..12, req lag=8 len=8 -> dout 5..12, crossing address 7 -> 0 correctly.
- Backpressure: same window with dout_ready toggling 1,0,0,1,0,1… -> each sample emitted exactly once, in order, dout held stable while stalled.
- Freeze: en=1 with incrementing din during readout -> fill/wptr unchanged until IDLE, emitted data unaffected. With HISTORY_READER_LIVE_EN defined: dout_ready=0 for 10 cycles with lag=8 -> overrun=1.
- Assert rst_n low mid-READ -> dout_valid=0 immediately; after release req_ready=1, fill=0, and a new lag=1 request after one write returns that sample.

Source files
------------

// File: rtl/history_reader_pkg.sv
// Shared types and helpers for the history window reader.
package history_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int lw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    // (a - b) mod depth for a < depth, b <= depth: one borrow bit plus a
    // conditional add instead of a real modulo.
    function automatic logic [31:0] wrap_sub(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] depth
    );
        logic [32:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[32]) d = d + {1'b0, depth};
        return d[31:0];
    endfunction

endpackage

// File: rtl/history_reader_sdp_ram_rf.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
module sdp_ram_rf #(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/history_reader.sv
// Circular history RAM with windowed look-back readout over valid/ready.
// Define HISTORY_READER_LIVE_EN to keep writing during readout (adds overrun).
module history_reader
    import history_reader_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    localparam int LW   = lw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] din,
    input  logic          req,
    input  logic [LW-1:0] req_lag,
    input  logic [LW-1:0] req_len,
    output logic          req_ready,
    output logic          req_err,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic [LW-1:0] fill
`ifdef HISTORY_READER_LIVE_EN
    ,
    output logic          overrun
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] wptr, raddr;
    logic [LW-1:0] cnt;
    logic          we, rd_en, rd_vld, rd_last;
    logic [DW-1:0] rd_data, skid_data;
    logic          skid_valid, skid_last;
    logic          pop, space, req_ok, accept;
    logic [1:0]    occ;

`ifdef HISTORY_READER_LIVE_EN
    assign we = en;
`else
    assign we = en && (state == IDLE);
`endif

    assign pop    = dout_valid && dout_ready;
    assign occ    = 2'(dout_valid) + 2'(skid_valid) + 2'(rd_vld);
    // Issue only if the read landing next cycle is guaranteed a slot.
    assign space  = occ <= 2'(pop) + 2'd1;
    assign req_ok = (req_lag != '0) && (req_lag <= fill)
                 && (req_len != '0) && (req_len <= req_lag);
    assign accept = req && req_ready && req_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rd_en     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_nxt = READ;
            end
            READ: begin
                rd_en = space;
                if (space && cnt == LW'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && dout_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            fill <= '0;
        end else if (we) begin
            wptr <= (wptr == LAST_ADDR) ? '0 : wptr + AW'(1);
            if (fill != FULL) fill <= fill + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr   <= '0;
            cnt     <= '0;
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
            req_err <= 1'b0;
        end else begin
            if (accept) begin
                raddr <= AW'(wrap_sub(32'(wptr), 32'(req_lag), 32'(DEPTH)));
                cnt   <= req_len;
            end else if (rd_en) begin
                raddr <= (raddr == LAST_ADDR) ? '0 : raddr + AW'(1);
                cnt   <= cnt - LW'(1);
            end
            rd_vld  <= rd_en;
            rd_last <= rd_en && (cnt == LW'(1));
            req_err <= req && req_ready && !req_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
        end else if (!dout_valid || dout_ready) begin
            if (skid_valid) begin
                dout       <= skid_data;
                dout_last  <= skid_last;
                dout_valid <= 1'b1;
                skid_data  <= rd_data;
                skid_last  <= rd_last;
                skid_valid <= rd_vld;
            end else if (rd_vld) begin
                dout       <= rd_data;
                dout_last  <= rd_last;
                dout_valid <= 1'b1;
            end else begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end
        end else if (rd_vld) begin
            skid_data  <= rd_data;
            skid_last  <= rd_last;
            skid_valid <= 1'b1;
        end
    end

`ifdef HISTORY_READER_LIVE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (accept) begin
            overrun <= 1'b0;
        end else if (we && state == READ && cnt != '0 && wptr == raddr) begin
            overrun <= 1'b1;
        end
    end
`endif

    sdp_ram_rf #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata (din),
        .re    (rd_en),
        .raddr (raddr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_history_reader.sv
// Scoreboard bench for history_reader (DW=8, DEPTH=8).
module tb_history_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          req = 1'b0;
    logic [LW-1:0] req_lag = '0;
    logic [LW-1:0] req_len = '0;
    logic          req_ready, req_err;
    logic [DW-1:0] dout;
    logic          dout_valid, dout_last;
    logic          dout_ready = 1'b1;
    logic [LW-1:0] fill;
`ifdef HISTORY_READER_LIVE_EN
    logic          overrun;
`endif

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] hist[$];
    exp_t          e;
    int            n_chk = 0;
    int            n_pass = 0;
    bit            ign_data = 0;
    logic          stall_q = 1'b0;
    logic [DW:0]   hold_q = '0;
    bit            ok;

    history_reader #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .din        (din),
        .req        (req),
        .req_lag    (req_lag),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .req_err    (req_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .fill       (fill)
`ifdef HISTORY_READER_LIVE_EN
        ,
        .overrun    (overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_seq(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            en  = 1'b1;
            din = DW'(first + i);
            @(posedge clk);
            hist.push_back(DW'(first + i));
            #1;
        end
        en = 1'b0;
    endtask

    task automatic request(input int lag, input int len, output bit acc);
        int f;
        int base;
        f    = (hist.size() > DEPTH) ? DEPTH : hist.size();
        acc  = (lag >= 1) && (lag <= f) && (len >= 1) && (len <= lag);
        base = hist.size() - lag;
        if (acc)
            for (int k = 0; k < len; k++)
                sb.push_back(exp_t'{last: (k == len - 1), data: hist[base + k]});
        req     = 1'b1;
        req_lag = LW'(lag);
        req_len = LW'(len);
        step();
        req = 1'b0;
        if (!acc) begin
            chk("err_pulse", 32'(req_err), 1);
            chk("err_ready", 32'(req_ready), 1);
            chk("err_novalid", 32'(dout_valid), 0);
            step();
            chk("err_clear", 32'(req_err), 0);
            chk("err_novalid2", 32'(dout_valid), 0);
        end else begin
            chk("acc_busy", 32'(req_ready), 0);
            chk("acc_noerr", 32'(req_err), 0);
        end
    endtask

    task automatic wait_idle(input logic [5:0] pat, input bit fz,
                             input int budget);
        int i;
        i = 0;
        while (!(req_ready && sb.size() == 0) && i < budget) begin
            dout_ready = pat[i % 6];
            if (fz) begin
                en  = 1'b1;
                din = DW'(8'h80 + i);
            end
            step();
            i++;
        end
        en = 1'b0;
        dout_ready = 1'b1;
        chk("idle_in_time", 32'(i < budget), 1);
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) chk("hold", 32'({dout_last, dout}), 32'(hold_q));
            if (dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    if (!ign_data) chk("dout", 32'(dout), 32'(e.data));
                    chk("last", 32'(dout_last), 32'(e.last));
                end
            end
            stall_q <= dout_valid && !dout_ready;
            hold_q  <= {dout_last, dout};
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        hist.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        do_reset();
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_err", 32'(req_err), 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_last", 32'(dout_last), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_fill", 32'(fill), 0);

        write_seq(1, 10);
        chk("fill_sat", 32'(fill), DEPTH);
        request(3, 3, ok);
        chk("lat0", 32'(dout_valid), 0);
        step();
        chk("lat1", 32'(dout_valid), 0);
        step();
        chk("lat2", 32'(dout_valid), 1);
        wait_idle(6'h3F, 1'b0, 50);
        chk("ready_back", 32'(req_ready), 1);

        do_reset();
        write_seq(8'h11, 5);
        chk("fill5", 32'(fill), 5);
        request(6, 1, ok);
        request(0, 0, ok);
        request(3, 0, ok);
        request(3, 4, ok);
        request(5, 5, ok);
        wait_idle(6'h3F, 1'b0, 50);

        do_reset();
        write_seq(1, 12);
        request(8, 8, ok);
        wait_idle(6'h3F, 1'b0, 50);
        request(8, 8, ok);
        wait_idle(6'b101001, 1'b0, 100);
        chk("fill_bp", 32'(fill), DEPTH);

`ifdef HISTORY_READER_LIVE_EN
        request(8, 8, ok);
        ign_data   = 1;
        dout_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en  = 1'b1;
            din = DW'(8'hC0 + i);
            @(posedge clk);
            hist.push_back(DW'(8'hC0 + i));
            #1;
        end
        en = 1'b0;
        chk("overrun_set", 32'(overrun), 1);
        wait_idle(6'h3F, 1'b0, 50);
        ign_data = 0;
        request(1, 1, ok);
        chk("overrun_clr", 32'(overrun), 0);
        wait_idle(6'h3F, 1'b0, 50);
`else
        request(4, 4, ok);
        wait_idle(6'b101001, 1'b1, 100);
        chk("freeze_fill", 32'(fill), DEPTH);
        request(1, 1, ok);
        wait_idle(6'h3F, 1'b0, 50);
`endif

        request(8, 8, ok);
        step();
        step();
        step();
        rst_n = 1'b0;
        sb.delete();
        hist.delete();
        #1;
        chk("rst_mid_valid", 32'(dout_valid), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_mid_ready", 32'(req_ready), 1);
        chk("rst_mid_fill", 32'(fill), 0);
        chk("rst_mid_quiet", 32'(dout_valid), 0);
        write_seq(8'h5A, 1);
        request(1, 1, ok);
        wait_idle(6'h3F, 1'b0, 50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
